// File: rtl/rocc_cmd_issue_ctrl.sv
// Credit-based issue controller feeding the cmdq and ximm1q enqueue ports, with a flush/drain sequence.
// Optional fire/replay statistics counters are built when ISSUE_STATS_EN is defined.
module rocc_cmd_issue_ctrl #(
  parameter int CMDQ_DEPTH   = 8,
  parameter int XIMM1Q_DEPTH = 4,
  parameter int CMD_W        = 32,
  parameter int IMM_W        = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_valid,
  input  logic             io_sigs_enq_cmdq,
  input  logic             io_sigs_enq_ximm1q,
  input  logic [CMD_W-1:0] io_cmd,
  input  logic [IMM_W-1:0] io_imm,
  output logic             io_fire,
  output logic             io_replay,
  input  logic             io_flush,
  output logic             io_cmdq_valid,
  output logic [CMD_W-1:0] io_cmdq_bits,
  output logic             io_ximm1q_valid,
  output logic [IMM_W-1:0] io_ximm1q_bits,
  input  logic             io_cmdq_deq,
  input  logic             io_ximm1q_deq,
`ifdef ISSUE_STATS_EN
  output logic [31:0]      io_stat_fire,
  output logic [31:0]      io_stat_replay,
`endif
  output logic             io_busy,
  output logic             io_cred_err
);

  localparam int CW = $clog2(CMDQ_DEPTH + 1);
  localparam int XW = $clog2(XIMM1Q_DEPTH + 1);
  localparam logic [CW-1:0] C_FULL = CW'(CMDQ_DEPTH);
  localparam logic [XW-1:0] X_FULL = XW'(XIMM1Q_DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cred_c_reg, cred_c_next;
  logic [XW-1:0]   cred_x_reg, cred_x_next;
  logic            err_c, err_x;
  logic            cred_err_reg;
  logic            cmdq_valid_reg, ximm1q_valid_reg;
  logic [CMD_W-1:0] cmdq_bits_reg;
  logic [IMM_W-1:0] ximm1q_bits_reg;
  logic            ok_c, ok_x, take_c, take_x;

  // Acceptance looks only at registered credits, so a same-cycle return never unblocks issue.
  assign ok_c      = !io_sigs_enq_cmdq   || (cred_c_reg != '0);
  assign ok_x      = !io_sigs_enq_ximm1q || (cred_x_reg != '0);
  assign io_fire   = io_valid && (state_reg == ST_RUN) && !io_flush && ok_c && ok_x;
  assign io_replay = io_valid && !io_fire;
  assign take_c    = io_fire && io_sigs_enq_cmdq;
  assign take_x    = io_fire && io_sigs_enq_ximm1q;

  always_comb begin
    cred_c_next = cred_c_reg;
    err_c       = 1'b0;
    if (take_c && !io_cmdq_deq) begin
      cred_c_next = cred_c_reg - CW'(1);
    end else if (!take_c && io_cmdq_deq) begin
      if (cred_c_reg == C_FULL) err_c = 1'b1;
      else                      cred_c_next = cred_c_reg + CW'(1);
    end
  end

  always_comb begin
    cred_x_next = cred_x_reg;
    err_x       = 1'b0;
    if (take_x && !io_ximm1q_deq) begin
      cred_x_next = cred_x_reg - XW'(1);
    end else if (!take_x && io_ximm1q_deq) begin
      if (cred_x_reg == X_FULL) err_x = 1'b1;
      else                      cred_x_next = cred_x_reg + XW'(1);
    end
  end

  // Drain exits once both queues have returned every credit; flush is ignored while draining.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:   if (io_flush) state_next = ST_DRAIN;
      ST_DRAIN: if ((cred_c_reg == C_FULL) && (cred_x_reg == X_FULL)) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_RUN;
      cred_c_reg       <= C_FULL;
      cred_x_reg       <= X_FULL;
      cred_err_reg     <= 1'b0;
      cmdq_valid_reg   <= 1'b0;
      ximm1q_valid_reg <= 1'b0;
      cmdq_bits_reg    <= '0;
      ximm1q_bits_reg  <= '0;
    end else begin
      state_reg        <= state_next;
      cred_c_reg       <= cred_c_next;
      cred_x_reg       <= cred_x_next;
      cred_err_reg     <= cred_err_reg || err_c || err_x;
      cmdq_valid_reg   <= take_c;
      ximm1q_valid_reg <= take_x;
      if (take_c) cmdq_bits_reg   <= io_cmd;
      if (take_x) ximm1q_bits_reg <= io_imm;
    end
  end

  assign io_cmdq_valid   = cmdq_valid_reg;
  assign io_cmdq_bits    = cmdq_bits_reg;
  assign io_ximm1q_valid = ximm1q_valid_reg;
  assign io_ximm1q_bits  = ximm1q_bits_reg;
  assign io_busy         = (state_reg == ST_DRAIN);
  assign io_cred_err     = cred_err_reg;

`ifdef ISSUE_STATS_EN
  logic [31:0] stat_fire_reg, stat_replay_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fire_reg   <= '0;
      stat_replay_reg <= '0;
    end else begin
      if (io_fire)   stat_fire_reg   <= stat_fire_reg + 32'd1;
      if (io_replay) stat_replay_reg <= stat_replay_reg + 32'd1;
    end
  end

  assign io_stat_fire   = stat_fire_reg;
  assign io_stat_replay = stat_replay_reg;
`endif

endmodule
